uart_rx_sampler: RTL
====================

# uart_rx_sampler

Oversampling front end of the UART receiver. Synchronises the serial line, runs the edge counter (oversampling ticks inside a bit) and the bit counter (bit position inside a frame), and produces one voted data bit per bit period. It feeds the receive FSM (`rx_sync`, `bit_cnt`, `sampled_bit`), the deserializer and the parity/start/stop checkers, and takes its enables (`edge_cnt_en`, `data_sample_en`) back from the FSM.

## Interface
- `PRESCALE_W`, default 6: width of the prescale and edge counter.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-low.
- `rx_in` input 1: raw serial line, asynchronous to `clk`, idle high.
- `prescale` input `PRESCALE_W`: oversampling ratio.
  - Legal values are 8, 16 and 32.
- `par_en` input 1: frame carries a parity bit.
- `edge_cnt_en` input 1: run the edge and bit counters (from the FSM).
- `data_sample_en` input 1: allow bit sampling (from the FSM).
- `rx_sync` output 1: `rx_in` after the 2-flop synchroniser; the FSM start detect uses this signal.
- `edge_cnt` output `PRESCALE_W`: current tick inside the bit, 0..pre-1.
- `bit_cnt` output 4: bit index in the frame.
  - 0 = start, 1..8 = data, 9 = parity (or stop when there is no parity), 10 = stop.
- `sampled_bit` output 1: voted value of the current bit.
- `sample_valid` output 1: one-cycle pulse when `sampled_bit` has just been updated.

## Operation
- Synchroniser: two flops, reset to 1. `rx_sync` lags `rx_in` by 2 clk.
- Prescale latch: `pre` ← `prescale` on every cycle with `edge_cnt_en`=0.
  - `pre` is held for as long as `edge_cnt_en`=1, so a prescale change mid-frame takes effect only on the next frame.
  - An illegal `prescale` latches as 8.
  - `pre` resets to 8.
- `mid` = `pre` >> 1.
- `last` = `par_en` ? 10 : 9. `par_en` is sampled combinationally.
- Edge counter, when `edge_cnt_en`=1:
  - If `edge_cnt` == `pre`−1: `edge_cnt` ← 0.
  - Otherwise: `edge_cnt` ← `edge_cnt`+1.
- Bit counter, when `edge_cnt_en`=1 and `edge_cnt` == `pre`−1:
  - If `bit_cnt` == `last`: `bit_cnt` ← 0.
  - Otherwise: `bit_cnt` ← `bit_cnt`+1.
- Counters with `edge_cnt_en`=0: `edge_cnt` and `bit_cnt` clear to 0 synchronously on the next edge.
- Back-to-back frames: the counters are not cleared at wrap, so continuous counting handles consecutive frames without a gap.
- Sampling (with `UART_RX_MAJORITY_EN`): while `data_sample_en`=1 and `edge_cnt_en`=1, `rx_sync` is captured into s0, s1, s2 on the cycles where `edge_cnt` = `mid`−1, `mid`, `mid`+1.
- Vote: on the cycle `edge_cnt` == `mid`+1 the block registers
  - `sampled_bit` ← majority(s0, s1, `rx_sync`);
  - `sample_valid` ← 1.
- `sample_valid` is 0 on every other cycle.
- `sampled_bit` holds its value between updates.
- `data_sample_en`=0 suppresses sample capture and the `sample_valid` pulse. Counters keep running.

## Timing
- Reset values: `rx_sync`=1, `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1, `sample_valid`=0, s0..s2=1, `pre`=8.
- Reset asserted mid-frame: all state returns to the reset values immediately (asynchronous), with no partial-frame residue.
- Sample latency: `sampled_bit` and `sample_valid` update on the clk edge after the cycle with `edge_cnt` == `mid`+1. That is `mid`+2 clk after the bit's `edge_cnt`=0 cycle.
- Bit boundary: `bit_cnt` changes on the same edge on which `edge_cnt` returns to 0.
- Frame length: (`last`+1)·`pre` clk from the first `edge_cnt_en`=1 cycle to `bit_cnt` returning to 0.
- `edge_cnt_en` falling on the exact `pre`−1 tick: the clear wins; `bit_cnt` does not increment.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - three-sample majority vote as described under Operation;
  - a single-tick glitch inside the voting window is rejected.
- `UART_RX_MAJORITY_EN` undefined:
  - s0/s1 are not built;
  - `sampled_bit` ← `rx_sync` sampled at `edge_cnt` == `mid`;
  - `sample_valid` pulses on the following edge, so latency is `mid`+1;
  - all other behaviour is identical.

## Test plan
- Clean frame: `prescale`=8, `par_en`=1, frame 0xA5 LSB-first, even parity, stop bit.
  - 11 `sample_valid` pulses.
  - Sampled bits 0,1,0,1,0,0,1,0,1,0,1.
  - `bit_cnt` runs 0..10, then 0; frame length 88 clk.
- Glitch rejection: `prescale`=16, data bit 1 forced low only at tick `mid`.
  - With the macro, `sampled_bit`=1.
  - Without the macro, `sampled_bit`=0.
- No parity: `prescale`=32, `par_en`=0.
  - `bit_cnt` wraps 9→0 after 320 clk.
  - 10 `sample_valid` pulses.
- Prescale handling:
  - `prescale` changed 16→8 mid-frame: bit period stays 16 until `edge_cnt_en` drops.
  - `prescale`=12 latches as 8.
- Enables:
  - `edge_cnt_en` dropped at `bit_cnt`=4: `edge_cnt`=`bit_cnt`=0 next cycle.
  - `data_sample_en`=0: no `sample_valid` pulses.
- Reset: `rst` low at `bit_cnt`=6.
  - All outputs at reset values immediately.
  - The next frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// UART receive oversampling front end: line synchroniser, edge/bit counters and per-bit sampler.
// Define UART_RX_MAJORITY_EN for a three-sample majority vote around mid-bit; otherwise a single mid-bit sample.
module uart_rx_sampler #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  edge_cnt_en,
   input  logic                  data_sample_en,
   output logic                  rx_sync,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [3:0]            bit_cnt,
   output logic                  sampled_bit,
   output logic                  sample_valid
);

   localparam logic [PRESCALE_W-1:0] PRE_DEF = PRESCALE_W'(8);
   localparam logic [PRESCALE_W-1:0] ONE     = PRESCALE_W'(1);

   logic [1:0]            sync_reg;
   logic [PRESCALE_W-1:0] pre_reg, pre_next;
   logic [PRESCALE_W-1:0] edge_cnt_reg, edge_cnt_next;
   logic [3:0]            bit_cnt_reg, bit_cnt_next;
   logic                  sampled_bit_reg, sampled_bit_next;
   logic                  sample_valid_reg, sample_valid_next;
   logic [PRESCALE_W-1:0] mid;
   logic [PRESCALE_W-1:0] pre_last;
   logic [3:0]            last;
   logic                  bit_end;
   logic                  sample_en;
   logic                  prescale_legal;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx_in};
      end
   end

   assign rx_sync = sync_reg[1];

   assign prescale_legal = (prescale == PRESCALE_W'(8))  ||
                           (prescale == PRESCALE_W'(16)) ||
                           (prescale == PRESCALE_W'(32));
   assign mid       = pre_reg >> 1;
   assign pre_last  = pre_reg - ONE;
   assign last      = par_en ? 4'd10 : 4'd9;
   assign bit_end   = (edge_cnt_reg == pre_last);
   assign sample_en = edge_cnt_en & data_sample_en;

   // Ratio only follows the input while idle, so a frame keeps one bit period throughout.
   always_comb begin
      pre_next = pre_reg;
      if (!edge_cnt_en) begin
         pre_next = prescale_legal ? prescale : PRE_DEF;
      end
   end

   // Counters are not cleared on frame wrap so back-to-back frames count without a gap.
   always_comb begin
      edge_cnt_next = '0;
      bit_cnt_next  = '0;
      if (edge_cnt_en) begin
         edge_cnt_next = bit_end ? '0 : edge_cnt_reg + ONE;
         bit_cnt_next  = bit_cnt_reg;
         if (bit_end) begin
            bit_cnt_next = (bit_cnt_reg == last) ? 4'd0 : bit_cnt_reg + 4'd1;
         end
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic s0_reg, s0_next;
   logic s1_reg, s1_next;

   // The third vote sample is the live rx_sync on the mid+1 tick, so it needs no register.
   always_comb begin
      s0_next           = s0_reg;
      s1_next           = s1_reg;
      sampled_bit_next  = sampled_bit_reg;
      sample_valid_next = 1'b0;
      if (sample_en) begin
         if (edge_cnt_reg == mid - ONE) begin
            s0_next = rx_sync;
         end
         if (edge_cnt_reg == mid) begin
            s1_next = rx_sync;
         end
         if (edge_cnt_reg == mid + ONE) begin
            sampled_bit_next  = (s0_reg & s1_reg) | (s0_reg & rx_sync) | (s1_reg & rx_sync);
            sample_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_reg <= 1'b1;
         s1_reg <= 1'b1;
      end else begin
         s0_reg <= s0_next;
         s1_reg <= s1_next;
      end
   end
`else
   always_comb begin
      sampled_bit_next  = sampled_bit_reg;
      sample_valid_next = 1'b0;
      if (sample_en && (edge_cnt_reg == mid)) begin
         sampled_bit_next  = rx_sync;
         sample_valid_next = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_reg          <= PRE_DEF;
         edge_cnt_reg     <= '0;
         bit_cnt_reg      <= 4'd0;
         sampled_bit_reg  <= 1'b1;
         sample_valid_reg <= 1'b0;
      end else begin
         pre_reg          <= pre_next;
         edge_cnt_reg     <= edge_cnt_next;
         bit_cnt_reg      <= bit_cnt_next;
         sampled_bit_reg  <= sampled_bit_next;
         sample_valid_reg <= sample_valid_next;
      end
   end

   assign edge_cnt     = edge_cnt_reg;
   assign bit_cnt      = bit_cnt_reg;
   assign sampled_bit  = sampled_bit_reg;
   assign sample_valid = sample_valid_reg;

endmodule
